// File: rtl/harry_pkg.sv
// harry_pkg
// Shared definitions for the Harry sprite path. The sprite ROM decodes the
// same HARRY_* codes, so this package is the single source of truth for them.
//   - HARRY_* : 4-bit sprite select codes (0..9)
//   - anim_mode_t : animation mode of harry_anim_ctrl
//   - run_next / clamp_code : small code helpers
package harry_pkg;

  localparam logic [3:0] HARRY_STAND  = 4'd0;
  localparam logic [3:0] HARRY_JUMP   = 4'd1;
  localparam logic [3:0] HARRY_RUN1   = 4'd2;
  localparam logic [3:0] HARRY_RUN2   = 4'd3;
  localparam logic [3:0] HARRY_RUN3   = 4'd4;
  localparam logic [3:0] HARRY_RUN4   = 4'd5;
  localparam logic [3:0] HARRY_RUN5   = 4'd6;
  localparam logic [3:0] HARRY_VINE   = 4'd7;
  localparam logic [3:0] HARRY_CLIMB1 = 4'd8;
  localparam logic [3:0] HARRY_CLIMB2 = 4'd9;

  typedef enum logic [2:0] {
    MODE_STAND = 3'd0,
    MODE_RUN   = 3'd1,
    MODE_JUMP  = 3'd2,
    MODE_VINE  = 3'd3,
    MODE_CLIMB = 3'd4
  } anim_mode_t;

  // Next run frame: RUN1..RUN5 then back to RUN1.
  function automatic logic [3:0] run_next(input logic [3:0] c);
    return (c >= HARRY_RUN5) ? HARRY_RUN1 : c + 4'd1;
  endfunction

  // Any code outside 0..9 has no sprite; show the standing frame instead.
  function automatic logic [3:0] clamp_code(input logic [3:0] c);
    return (c > HARRY_CLIMB2) ? HARRY_STAND : c;
  endfunction

endpackage

// File: rtl/harry_anim_ctrl_if.sv
// harry_anim_ctrl_if
// Signal bundle between the game/physics side (master) and harry_anim_ctrl
// (slave).
//   master drives : frame_tick, move_left, move_right, jump_req, grounded,
//                   on_vine, on_ladder, climb_move
//   slave drives  : harry_state[3:0], facing_left, jump_active,
//                   jump_height[JH_W-1:0], anim_mode (debug view of the FSM)
// Optional (macro HARRY_STATE_OVERRIDE_EN): master also drives dbg_sel and
// dbg_state[3:0].
//
// Handshake: there is no valid/ready pair. frame_tick is a one-Clk strobe per
// video frame; all other master signals are levels sampled only on Clk edges
// where frame_tick=1. Slave outputs are registered, change only in the Clk
// after a tick and hold otherwise (the debug override excepted).
interface harry_anim_ctrl_if #(
  parameter int JUMP_FRAMES = 32
) ();
  localparam int JH_W = $clog2(JUMP_FRAMES / 2 + 1);

  logic                   frame_tick;
  logic                   move_left;
  logic                   move_right;
  logic                   jump_req;
  logic                   grounded;
  logic                   on_vine;
  logic                   on_ladder;
  logic                   climb_move;
  logic [3:0]             harry_state;
  logic                   facing_left;
  logic                   jump_active;
  logic [JH_W-1:0]        jump_height;
  harry_pkg::anim_mode_t  anim_mode;

`ifdef HARRY_STATE_OVERRIDE_EN
  logic                   dbg_sel;
  logic [3:0]             dbg_state;

  modport master (
    output frame_tick, move_left, move_right, jump_req, grounded,
           on_vine, on_ladder, climb_move, dbg_sel, dbg_state,
    input  harry_state, facing_left, jump_active, jump_height, anim_mode
  );
  modport slave (
    input  frame_tick, move_left, move_right, jump_req, grounded,
           on_vine, on_ladder, climb_move, dbg_sel, dbg_state,
    output harry_state, facing_left, jump_active, jump_height, anim_mode
  );
`else
  modport master (
    output frame_tick, move_left, move_right, jump_req, grounded,
           on_vine, on_ladder, climb_move,
    input  harry_state, facing_left, jump_active, jump_height, anim_mode
  );
  modport slave (
    input  frame_tick, move_left, move_right, jump_req, grounded,
           on_vine, on_ladder, climb_move,
    output harry_state, facing_left, jump_active, jump_height, anim_mode
  );
`endif

endinterface

// File: rtl/anim_tick_div.sv
// anim_tick_div
// Modulo-N frame-tick counter used to pace sprite steps.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count at 0 (wins over en)
//   en         : count one tick
//   step       : combinational pulse on the counted tick that wraps N-1 -> 0
module anim_tick_div #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic step
);
  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;

  assign step = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/harry_anim_ctrl.sv
// harry_anim_ctrl
// Upstream stage of the Harry sprite ROM: turns per-frame player/physics
// levels into the sprite code, a facing flag and a jump height offset.
// Everything advances only on frame_tick, so animation speed is independent
// of the Clk frequency.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   bus (slave)  : inputs frame_tick, move_left, move_right, jump_req,
//                  grounded, on_vine, on_ladder, climb_move; outputs
//                  harry_state, facing_left, jump_active, jump_height,
//                  anim_mode (debug)
// Optional macro HARRY_STATE_OVERRIDE_EN: dbg_sel/dbg_state force
// harry_state on every Clk while the FSM keeps running underneath.
module harry_anim_ctrl
  import harry_pkg::*;
#(
  parameter int RUN_FRAME_DIV   = 4,
  parameter int CLIMB_FRAME_DIV = 8,
  parameter int JUMP_FRAMES     = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  harry_anim_ctrl_if.slave bus
);
  localparam int JH_W = $clog2(JUMP_FRAMES / 2 + 1);
  localparam int J_W  = $clog2(JUMP_FRAMES);
  localparam logic [J_W-1:0] J_LAST = J_W'(JUMP_FRAMES - 1);
  localparam logic [J_W-1:0] J_HALF = J_W'(JUMP_FRAMES / 2);
  // May wrap to 0 for power-of-two lengths; the modular subtraction below
  // still yields JUMP_FRAMES - j.
  localparam logic [J_W-1:0] J_FULL = J_W'(JUMP_FRAMES);

  logic tick;
  logic move_one;
  assign tick     = bus.frame_tick;
  assign move_one = bus.move_left ^ bus.move_right;

  anim_mode_t      mode_q, mode_d;
  logic [3:0]      code_q, code_d;
  logic [J_W-1:0]  j_q, j_d;
  logic [JH_W-1:0] jh_q, jh_d;
  logic            jact_q, jact_d;
  logic            face_q, face_d;
  logic            armed_q, armed_d;
  logic            jump_go;
  logic            run_clr, run_en, run_step;
  logic            climb_clr, climb_en, climb_step;

  // Mode selection, in priority order. The jump rule is checked for any
  // non-JUMP mode, which gives VINE/CLIMB their "re-evaluate from the jump
  // rule" exit once their flag drops. A JUMP that just expired skips the
  // jump rule and falls through to run/stand.
  always_comb begin
    mode_d  = mode_q;
    jump_go = 1'b0;
    if (tick) begin
      if (bus.on_vine) begin
        mode_d = MODE_VINE;
      end else if (bus.on_ladder && mode_q != MODE_JUMP) begin
        mode_d = MODE_CLIMB;
      end else if (mode_q == MODE_JUMP && j_q != J_LAST) begin
        mode_d = MODE_JUMP;
      end else if (mode_q != MODE_JUMP && bus.jump_req && bus.grounded && armed_q) begin
        mode_d  = MODE_JUMP;
        jump_go = 1'b1;
      end else if (move_one) begin
        mode_d = MODE_RUN;
      end else begin
        mode_d = MODE_STAND;
      end
    end
  end

  // Dividers restart on entry; leaving a mode simply stops using its phase.
  assign run_clr   = tick && mode_d == MODE_RUN   && mode_q != MODE_RUN;
  assign run_en    = tick && mode_d == MODE_RUN   && mode_q == MODE_RUN;
  assign climb_clr = tick && mode_d == MODE_CLIMB && mode_q != MODE_CLIMB;
  assign climb_en  = tick && mode_d == MODE_CLIMB && mode_q == MODE_CLIMB && bus.climb_move;

  anim_tick_div #(.N(RUN_FRAME_DIV)) u_run_div (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (run_clr),
    .en    (run_en),
    .step  (run_step)
  );

  anim_tick_div #(.N(CLIMB_FRAME_DIV)) u_climb_div (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (climb_clr),
    .en    (climb_en),
    .step  (climb_step)
  );

  // Sprite code for the selected mode.
  always_comb begin
    code_d = code_q;
    if (tick) begin
      case (mode_d)
        MODE_STAND: code_d = HARRY_STAND;
        MODE_JUMP:  code_d = HARRY_JUMP;
        MODE_VINE:  code_d = HARRY_VINE;
        MODE_RUN: begin
          if (mode_q != MODE_RUN)  code_d = HARRY_RUN1;
          else if (run_step)       code_d = run_next(code_q);
        end
        MODE_CLIMB: begin
          if (mode_q != MODE_CLIMB) code_d = HARRY_CLIMB1;
          else if (climb_step)
            code_d = (code_q == HARRY_CLIMB1) ? HARRY_CLIMB2 : HARRY_CLIMB1;
        end
        default: code_d = HARRY_STAND;
      endcase
    end
  end

  // Jump counter, jump arming, facing and the jump outputs. The jump only
  // re-arms once jump_req has been seen low on a tick. Facing is frozen
  // whenever the mode being entered or held is JUMP or VINE.
  always_comb begin
    j_d     = j_q;
    armed_d = armed_q;
    face_d  = face_q;
    if (tick) begin
      if (mode_d != MODE_JUMP || jump_go) j_d = '0;
      else                                j_d = j_q + J_W'(1);
      if (jump_go)           armed_d = 1'b0;
      else if (!bus.jump_req) armed_d = 1'b1;
      if (move_one && mode_d != MODE_JUMP && mode_d != MODE_VINE)
        face_d = bus.move_left;
    end
    jact_d = (mode_d == MODE_JUMP);
    if (mode_d != MODE_JUMP)  jh_d = '0;
    else if (j_d <= J_HALF)   jh_d = JH_W'(j_d);
    else                      jh_d = JH_W'(J_FULL - j_d);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mode_q  <= MODE_STAND;
      code_q  <= HARRY_STAND;
      j_q     <= '0;
      jh_q    <= '0;
      jact_q  <= 1'b0;
      face_q  <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      mode_q  <= mode_d;
      code_q  <= code_d;
      j_q     <= j_d;
      jh_q    <= jh_d;
      jact_q  <= jact_d;
      face_q  <= face_d;
      armed_q <= armed_d;
    end
  end

  assign bus.facing_left = face_q;
  assign bus.jump_active = jact_q;
  assign bus.jump_height = jh_q;
  assign bus.anim_mode   = mode_q;

`ifdef HARRY_STATE_OVERRIDE_EN
  // Separate output register: follows dbg_state on every Clk while selected,
  // and otherwise tracks the FSM code, so the FSM resumes one Clk after
  // dbg_sel falls.
  logic [3:0] state_q;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)         state_q <= HARRY_STAND;
    else if (bus.dbg_sel) state_q <= clamp_code(bus.dbg_state);
    else                  state_q <= code_d;
  end
  assign bus.harry_state = state_q;
`else
  assign bus.harry_state = code_q;
`endif

endmodule

// File: doc/harry_anim_ctrl.md
Name: harry_anim_ctrl

Overview:
Upstream stage of the Harry sprite ROM. Turns per-frame player/physics inputs into the 4-bit harry_state sprite select code (0..9), a facing flag and a jump height offset. The sprite mux and the draw logic consume these outputs. All updates happen on frame ticks (one per vsync), so the animation rate does not depend on Clk frequency.

Parameters:
RUN_FRAME_DIV, 4, frame ticks per run-sprite step
CLIMB_FRAME_DIV, 8, frame ticks per climb-sprite toggle
JUMP_FRAMES, 32, total frame ticks spent in a jump (even, >=4)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-Clk pulse per video frame
move_left  in  1  left input held
move_right  in  1  right input held
jump_req  in  1  jump button level
grounded  in  1  physics: feet on floor
on_vine  in  1  physics: holding vine
on_ladder  in  1  physics: on ladder
climb_move  in  1  up/down held while on ladder
harry_state  out  4  sprite code to sprite ROM
facing_left  out  1  horizontal mirror request
jump_active  out  1  high while in JUMP
jump_height  out  $clog2(JUMP_FRAMES/2+1)  vertical offset in pixels, upward

Behaviour:
- One clock (Clk). Reset is asynchronous and active-low (Reset_n).
- Reset values: harry_state=0, facing_left=0, jump_active=0, jump_height=0, all counters 0, mode STAND.
- All state, counters and outputs update only on Clk edges where frame_tick=1. Outputs are registered and become valid one Clk after the tick. Between ticks, outputs hold.
- Mode FSM: STAND, RUN, JUMP, VINE, CLIMB. Exit conditions are evaluated in this priority order on each tick:
  1. on_vine=1 -> VINE from any mode, including mid-JUMP (catching the vine). Code 7. The jump counter clears and height goes to 0.
  2. on_ladder=1 and not JUMP -> CLIMB.
  3. JUMP holds until its counter expires.
  4. STAND/RUN with jump_req=1 and grounded=1 -> JUMP.
  5. Exactly one of move_left/move_right -> RUN.
  6. Otherwise -> STAND (code 0).
- VINE/CLIMB exit: when the flag drops, re-evaluate from rule 4 in the same tick.
- RUN:
  - On entry, code 2 and sub-counter 0.
  - Code advances 2,3,4,5,6,2,... every RUN_FRAME_DIV ticks.
  - Leaving RUN discards the phase; re-entry restarts at 2.
- JUMP:
  - Code 1, jump_active=1.
  - Counter j is 0 on the entry tick and increments each tick.
  - jump_height = j when j<=JUMP_FRAMES/2, else JUMP_FRAMES-j.
  - On the tick where j==JUMP_FRAMES-1, exit via rules 5/6. jump_height returns to 0 and jump_active to 0.
  - jump_req held through landing does not re-trigger until it is seen low on at least one tick (edge-armed).
- CLIMB:
  - Entry code 8.
  - While climb_move=1, toggle 8<->9 every CLIMB_FRAME_DIV ticks.
  - With climb_move=0, the code and sub-counter hold.
- facing_left:
  - Set on a tick with move_left only; cleared with move_right only.
  - Both or neither pressed: unchanged.
  - Frozen in JUMP and VINE.
- Both directions pressed in STAND/RUN counts as no move (rule 6).
- harry_state never leaves 0..9.

Optional Feature:
HARRY_STATE_OVERRIDE_EN:
- When defined, adds ports dbg_sel (in, 1) and dbg_state (in, 4).
- While dbg_sel=1, harry_state = dbg_state registered on every Clk, not only on ticks. Values >9 output 0.
- The FSM keeps running underneath and takes over the cycle after dbg_sel falls.
- When undefined, these ports are absent and there is no override logic.

Decomposition:
- harry_pkg:
  - Sprite code constants HARRY_STAND=0, HARRY_JUMP=1, HARRY_RUN1..RUN5=2..6, HARRY_VINE=7, HARRY_CLIMB1=8, HARRY_CLIMB2=9.
  - anim_mode_t enum.
  - The sprite ROM shares this package.
- One sub-module, anim_tick_div:
  - Parameterized modulo-N tick counter with clear and enable.
  - Emits a step pulse on wrap.
  - Instantiated twice (run, climb).

Test Plan:
- Reset_n low mid-RUN at code 4 -> all outputs 0 immediately (async). After release and no inputs, harry_state stays 0.
- move_right held, RUN_FRAME_DIV=4, 24 ticks -> code sequence 2,2,2,2,3,...,6,2 and wraps. facing_left=0. Release -> 0 on the next tick.
- grounded=1, jump_req pulse, JUMP_FRAMES=32:
  - harry_state=1 for 32 ticks.
  - jump_height peaks at 16 at j=16, then ramps 16..1.
  - Returns to 0/0.
  - Holding jump_req through landing does not re-jump.
- Mid-jump at j=10, assert on_vine -> next tick code 7, jump_height=0, jump_active=0. Drop on_vine with no inputs -> code 0.
- on_ladder=1, climb_move toggled, CLIMB_FRAME_DIV=8 -> 8 for 8 ticks, 9 for 8 ticks. climb_move=0 holds the current code indefinitely.
- With HARRY_STATE_OVERRIDE_EN: dbg_sel=1, dbg_state=5 -> code 5 next Clk without a tick. dbg_state=12 -> 0. dbg_sel=0 -> FSM code resumes.
